vfu_wb_arbiter: RTL and testbench
=================================

Name: vfu_wb_arbiter

Overview:
- Per-lane write-back responder for the req/gnt result interfaces driven by the vector ALU and the Multiplier/FPU.
- Accepts result beats (id, addr, wdata, be) from both units and buffers them in per-source queues.
- Arbitrates the queued beats round-robin onto a single VRF write port with a valid/ack handshake.
- Emits per-instruction write-back-done pulses back towards the lane sequencer.

Parameters:
- NrVInsn, 8, number of in-flight vector instruction ids; vid_t is $clog2(NrVInsn) bits.
- QueueDepth, 2, entries per source queue; must be >= 1.
- vaddr_t, logic, type of a VRF element address.
- DataWidth, 64, derived: $bits(elen_t); do not override.
- StrbWidth, 8, derived: DataWidth/8; do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- alu_result_req_i  in  1  ALU write request, held until granted.
- alu_result_id_i  in  vid_t  ALU instruction id.
- alu_result_addr_i  in  vaddr_t  ALU destination address.
- alu_result_wdata_i  in  DataWidth  ALU write data.
- alu_result_be_i  in  StrbWidth  ALU byte enables.
- alu_result_gnt_o  out  1  ALU beat accepted this cycle.
- mfpu_result_req_i, mfpu_result_id_i, mfpu_result_addr_i, mfpu_result_wdata_i, mfpu_result_be_i  in  (same widths as the ALU inputs)  MFPU write request and payload.
- mfpu_result_gnt_o  out  1  MFPU beat accepted this cycle.
- vrf_wr_valid_o  out  1  write beat presented to the VRF.
- vrf_wr_src_o  out  1  source of the presented beat: 0 = ALU, 1 = MFPU.
- vrf_wr_id_o  out  vid_t  id of the presented beat.
- vrf_wr_addr_o  out  vaddr_t  address of the presented beat.
- vrf_wr_data_o  out  DataWidth  data of the presented beat.
- vrf_wr_be_o  out  StrbWidth  byte enables of the presented beat.
- vrf_wr_ack_i  in  1  VRF accepted the beat this cycle.
- alu_wb_done_o  out  NrVInsn  one-hot pulse: an ALU beat of that id was written.
- mfpu_wb_done_o  out  NrVInsn  one-hot pulse: an MFPU beat of that id was written.

Behaviour:
- Reset: synchronous on rst_ni=0. Both queues empty, priority pointer = ALU, lock cleared. All outputs are 0 during reset and in the first cycle after it.
- Grant (responder side of req/gnt):
  - x_result_gnt_o = x_result_req_i & !queue_x_full. Purely combinational, with no path from vrf_wr_ack_i.
  - On gnt the payload is pushed into that source's queue.
  - The requester holds req and payload stable until gnt. gnt may be asserted in consecutive cycles.
- Latency: no bypass. A beat granted in cycle t is presentable at vrf_wr_valid_o in cycle t+1 at the earliest.
- Arbitration:
  - vrf_wr_valid_o = lock | (queue_alu not empty) | (queue_mfpu not empty).
  - When not locked and both queues are non-empty, the source named by the priority pointer wins. When only one is non-empty, that source wins.
  - Once vrf_wr_valid_o is high without ack, the lock sets. The same source and payload are then held stable until vrf_wr_ack_i.
- On vrf_wr_valid_o & vrf_wr_ack_i:
  - Pop the winning queue.
  - Set the priority pointer to the other source.
  - Clear the lock.
  - Assert <src>_wb_done_o[vrf_wr_id_o] for exactly that cycle. The done outputs are otherwise 0.
- Full queue:
  - gnt for that source is 0, even if a pop occurs in the same cycle; the requester retries next cycle.
  - The other source is unaffected.
- Simultaneous push and pop on a non-full queue are both performed, and the occupancy count is unchanged.
- Each queue is in-order FIFO with a wrap-around pointer. Beats from one source are written to the VRF in grant order.
- Beats from different sources have no mutual ordering guarantee.
- A payload is never modified: addr, data, be and id pass through bit-exact.
- Reset mid-operation: any queued or locked beats are discarded without done pulses.

Decomposition:
- ara_pkg provides vid_t, elen_t and NrVInsn.
- New in ara_pkg: typedef wb_beat_t (id, addr, wdata, be) and enum wb_src_e {WbSrcAlu=0, WbSrcMfpu=1}.
- One sub-module, wb_beat_fifo: parametric depth, stores wb_beat_t, provides push/pop/full/empty, uses synchronous active-low reset. It is instantiated twice.
- The arbiter, lock and done decode stay in the top module.

Test Plan:
- Single ALU beat: id=3, addr=0x10, data=0xDEADBEEF_CAFEF00D, be=0xFF, ack tied high.
  - Required: gnt in cycle t; vrf_wr_valid_o with the same payload and src=0 in cycle t+1; alu_wb_done_o=8'b0000_1000 in t+1.
- Both sources request continuously, ack tied high:
  - Required: VRF sources alternate 0,1,0,1…, starting with ALU after reset.
  - Each source sees a sustained grant rate with no loss or reordering.
- ack held low for 5 cycles with ALU streaming, QueueDepth=2:
  - Required: alu_result_gnt_o deasserts after 2 grants.
  - vrf_wr_* stays stable across all 5 cycles; the first ack pops the oldest beat.
- Lock check: MFPU beat presented and unacked, then an ALU beat arrives while priority points to ALU.
  - Required: the MFPU beat stays on the output until acked; the ALU beat follows next.
- Reset asserted with both queues holding 2 beats:
  - Required: the next cycle has valid=0, gnt=0 and done=0.
  - A new request is then served with ALU priority.
- Full-queue simultaneous pop: ALU queue full, ack in the same cycle as req.
  - Required: gnt=0 that cycle, gnt=1 the next cycle, occupancy returns to full.

Source files
------------

// File: rtl/ara_pkg.sv
// Shared lane types: instruction ids, element width and write-back beat/source definitions.
package ara_pkg;

    localparam int unsigned NrVInsn = 8;
    localparam int unsigned ElenWidth = 64;

    typedef logic [$clog2(NrVInsn)-1:0] vid_t;
    typedef logic [ElenWidth-1:0] elen_t;
    typedef logic [ElenWidth/8-1:0] strb_t;

    typedef enum logic {
        WbSrcAlu  = 1'b0,
        WbSrcMfpu = 1'b1
    } wb_src_e;

    // Default beat with a one-bit element address; users with a wider address rebuild it.
    typedef struct packed {
        vid_t  id;
        logic  addr;
        elen_t wdata;
        strb_t be;
    } wb_beat_t;

endpackage

// File: rtl/wb_beat_fifo.sv
// In-order queue of write-back beats with wrap-around pointers and synchronous active-low reset.
module wb_beat_fifo
    import ara_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter type beat_t = wb_beat_t
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  push_i,
    input  beat_t data_i,
    input  logic  pop_i,
    output beat_t data_o,
    output logic  full_o,
    output logic  empty_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    typedef logic [PtrWidth-1:0] ptr_t;
    localparam ptr_t LastPtr = ptr_t'(Depth - 1);

    beat_t               mem_q [Depth];
    ptr_t                wr_ptr_q, wr_ptr_d;
    ptr_t                rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                push, pop;

    assign full_o  = (cnt_q == CntWidth'(Depth));
    assign empty_o = (cnt_q == '0);
    assign push    = push_i & ~full_o;
    assign pop     = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + ptr_t'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + ptr_t'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/vfu_wb_arbiter.sv
// Buffers ALU and MFPU result beats and arbitrates them round-robin onto one VRF write port.
module vfu_wb_arbiter
    import ara_pkg::*;
#(
    parameter int unsigned QueueDepth = 2,
    parameter type vaddr_t = logic,
    localparam int unsigned DataWidth = $bits(elen_t),
    localparam int unsigned StrbWidth = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 alu_result_req_i,
    input  vid_t                 alu_result_id_i,
    input  vaddr_t               alu_result_addr_i,
    input  logic [DataWidth-1:0] alu_result_wdata_i,
    input  logic [StrbWidth-1:0] alu_result_be_i,
    output logic                 alu_result_gnt_o,
    input  logic                 mfpu_result_req_i,
    input  vid_t                 mfpu_result_id_i,
    input  vaddr_t               mfpu_result_addr_i,
    input  logic [DataWidth-1:0] mfpu_result_wdata_i,
    input  logic [StrbWidth-1:0] mfpu_result_be_i,
    output logic                 mfpu_result_gnt_o,
    output logic                 vrf_wr_valid_o,
    output logic                 vrf_wr_src_o,
    output vid_t                 vrf_wr_id_o,
    output vaddr_t               vrf_wr_addr_o,
    output logic [DataWidth-1:0] vrf_wr_data_o,
    output logic [StrbWidth-1:0] vrf_wr_be_o,
    input  logic                 vrf_wr_ack_i,
    output logic [NrVInsn-1:0]   alu_wb_done_o,
    output logic [NrVInsn-1:0]   mfpu_wb_done_o
);

    typedef struct packed {
        vid_t                 id;
        vaddr_t               addr;
        logic [DataWidth-1:0] wdata;
        logic [StrbWidth-1:0] be;
    } beat_t;

    beat_t   alu_in, mfpu_in, alu_head, mfpu_head, win;
    logic    alu_full, alu_empty, mfpu_full, mfpu_empty;
    logic    active_q, en, valid, fire;
    logic    lock_q, lock_d;
    wb_src_e lock_src_q, lock_src_d;
    wb_src_e prio_q, prio_d;
    wb_src_e src;

    // Held low for the first cycle after reset so no request is granted then.
    assign en = rst_ni & active_q;

    assign alu_in  = '{id: alu_result_id_i, addr: alu_result_addr_i,
                       wdata: alu_result_wdata_i, be: alu_result_be_i};
    assign mfpu_in = '{id: mfpu_result_id_i, addr: mfpu_result_addr_i,
                       wdata: mfpu_result_wdata_i, be: mfpu_result_be_i};

    assign alu_result_gnt_o  = en & alu_result_req_i & ~alu_full;
    assign mfpu_result_gnt_o = en & mfpu_result_req_i & ~mfpu_full;

    wb_beat_fifo #(
        .Depth  (QueueDepth),
        .beat_t (beat_t)
    ) i_alu_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (alu_result_gnt_o),
        .data_i  (alu_in),
        .pop_i   (fire && (src == WbSrcAlu)),
        .data_o  (alu_head),
        .full_o  (alu_full),
        .empty_o (alu_empty)
    );

    wb_beat_fifo #(
        .Depth  (QueueDepth),
        .beat_t (beat_t)
    ) i_mfpu_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (mfpu_result_gnt_o),
        .data_i  (mfpu_in),
        .pop_i   (fire && (src == WbSrcMfpu)),
        .data_o  (mfpu_head),
        .full_o  (mfpu_full),
        .empty_o (mfpu_empty)
    );

    assign valid = en & (lock_q | ~alu_empty | ~mfpu_empty);
    assign fire  = valid & vrf_wr_ack_i;

    always_comb begin
        src = WbSrcAlu;
        if (lock_q) begin
            src = lock_src_q;
        end else if (!alu_empty && !mfpu_empty) begin
            src = prio_q;
        end else if (alu_empty) begin
            src = WbSrcMfpu;
        end
    end

    assign win = (src == WbSrcMfpu) ? mfpu_head : alu_head;

    always_comb begin
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        prio_d     = prio_q;
        if (fire) begin
            lock_d = 1'b0;
            prio_d = (src == WbSrcAlu) ? WbSrcMfpu : WbSrcAlu;
        end else if (valid) begin
            lock_d     = 1'b1;
            lock_src_d = src;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            active_q   <= 1'b0;
            lock_q     <= 1'b0;
            lock_src_q <= WbSrcAlu;
            prio_q     <= WbSrcAlu;
        end else begin
            active_q   <= 1'b1;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            prio_q     <= prio_d;
        end
    end

    always_comb begin
        vrf_wr_valid_o = valid;
        vrf_wr_src_o   = valid & (src == WbSrcMfpu);
        vrf_wr_id_o    = valid ? win.id : '0;
        vrf_wr_addr_o  = valid ? win.addr : '0;
        vrf_wr_data_o  = valid ? win.wdata : '0;
        vrf_wr_be_o    = valid ? win.be : '0;
        alu_wb_done_o  = '0;
        mfpu_wb_done_o = '0;
        if (fire && (src == WbSrcAlu)) begin
            alu_wb_done_o = NrVInsn'(1) << win.id;
        end
        if (fire && (src == WbSrcMfpu)) begin
            mfpu_wb_done_o = NrVInsn'(1) << win.id;
        end
    end

endmodule

// File: tb/tb_vfu_wb_arbiter.sv
// Directed bench for vfu_wb_arbiter: grant timing, round-robin, backpressure, lock and reset.
module tb_vfu_wb_arbiter;

    typedef struct packed {
        logic [2:0]  id;
        logic [15:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
    } tb_beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_req = 1'b0, mfpu_req = 1'b0;
    logic [2:0]  alu_id = '0, mfpu_id = '0;
    logic [15:0] alu_addr = '0, mfpu_addr = '0;
    logic [63:0] alu_wdata = '0, mfpu_wdata = '0;
    logic [7:0]  alu_be = '0, mfpu_be = '0;
    logic        alu_gnt, mfpu_gnt;
    logic        wr_valid, wr_src, wr_ack = 1'b0;
    logic [2:0]  wr_id;
    logic [15:0] wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_be;
    logic [7:0]  alu_done, mfpu_done;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vfu_wb_arbiter #(
        .QueueDepth (2),
        .vaddr_t    (logic [15:0])
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .alu_result_req_i    (alu_req),
        .alu_result_id_i     (alu_id),
        .alu_result_addr_i   (alu_addr),
        .alu_result_wdata_i  (alu_wdata),
        .alu_result_be_i     (alu_be),
        .alu_result_gnt_o    (alu_gnt),
        .mfpu_result_req_i   (mfpu_req),
        .mfpu_result_id_i    (mfpu_id),
        .mfpu_result_addr_i  (mfpu_addr),
        .mfpu_result_wdata_i (mfpu_wdata),
        .mfpu_result_be_i    (mfpu_be),
        .mfpu_result_gnt_o   (mfpu_gnt),
        .vrf_wr_valid_o      (wr_valid),
        .vrf_wr_src_o        (wr_src),
        .vrf_wr_id_o         (wr_id),
        .vrf_wr_addr_o       (wr_addr),
        .vrf_wr_data_o       (wr_data),
        .vrf_wr_be_o         (wr_be),
        .vrf_wr_ack_i        (wr_ack),
        .alu_wb_done_o       (alu_done),
        .mfpu_wb_done_o      (mfpu_done)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic tb_beat_t mk_beat(input logic src, input int k);
        tb_beat_t b;
        b.id   = 3'(k + (src ? 3 : 0));
        b.addr = {7'd0, src, 8'(k)};
        b.data = {(src ? 32'hB0B0_0000 : 32'hA1A1_0000), 16'(k), 16'hC0DE};
        b.be   = 8'(k + 1);
        return b;
    endfunction

    function automatic tb_beat_t dut_beat();
        tb_beat_t b;
        b.id   = wr_id;
        b.addr = wr_addr;
        b.data = wr_data;
        b.be   = wr_be;
        return b;
    endfunction

    task automatic drive_alu(input tb_beat_t b);
        alu_id = b.id; alu_addr = b.addr; alu_wdata = b.data; alu_be = b.be;
    endtask

    task automatic drive_mfpu(input tb_beat_t b);
        mfpu_id = b.id; mfpu_addr = b.addr; mfpu_wdata = b.data; mfpu_be = b.be;
    endtask

    task automatic reset_dut();
        alu_req = 1'b0; mfpu_req = 1'b0; wr_ack = 1'b0; rst_n = 1'b0;
        next();
        rst_n = 1'b1;
        next();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; alu_req = 1'b1; mfpu_req = 1'b1; wr_ack = 1'b1;
        next();
        next();
        mid();
        n_checks++; if (alu_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_alu_gnt: got %b want 0", alu_gnt); end
        n_checks++; if (mfpu_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_mfpu_gnt: got %b want 0", mfpu_gnt); end
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", wr_valid); end
        next();
        rst_n = 1'b1;
        mid();
        n_checks++; if ({alu_gnt, mfpu_gnt} !== 2'b00) begin n_fail++; $display("FAIL post_rst_gnt: got %b want 00", {alu_gnt, mfpu_gnt}); end
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid: got %b want 0", wr_valid); end
        n_checks++; if ({alu_done, mfpu_done} !== 16'h0) begin n_fail++; $display("FAIL post_rst_done: got %h want 0000", {alu_done, mfpu_done}); end
        next();
        alu_req = 1'b0; mfpu_req = 1'b0; wr_ack = 1'b0;
    endtask

    task automatic test_single_alu();
        tb_beat_t b;
        b = '{id: 3'd3, addr: 16'h0010, data: 64'hDEADBEEF_CAFEF00D, be: 8'hFF};
        reset_dut();
        drive_alu(b); alu_req = 1'b1; wr_ack = 1'b1;
        mid();
        n_checks++; if (alu_gnt !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got %b want 1", alu_gnt); end
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b want 0", wr_valid); end
        next();
        alu_req = 1'b0;
        mid();
        n_checks++; if (wr_valid !== 1'b1 || wr_src !== 1'b0) begin n_fail++; $display("FAIL single_valid_src: got %b%b want 10", wr_valid, wr_src); end
        n_checks++; if (dut_beat() !== b) begin n_fail++; $display("FAIL single_payload: got %h want %h", dut_beat(), b); end
        n_checks++; if (alu_done !== 8'b0000_1000) begin n_fail++; $display("FAIL single_done: got %b want 00001000", alu_done); end
        n_checks++; if (mfpu_done !== 8'h00) begin n_fail++; $display("FAIL single_mfpu_done: got %b want 0", mfpu_done); end
        next();
        mid();
        n_checks++; if (wr_valid !== 1'b0 || alu_done !== 8'h00) begin n_fail++; $display("FAIL single_idle: got %b/%h want 0/00", wr_valid, alu_done); end
        next();
        wr_ack = 1'b0;
    endtask

    task automatic test_alternate();
        tb_beat_t q_alu [$];
        tb_beat_t q_mfpu [$];
        tb_beat_t exp;
        logic     exp_src;
        logic     have;
        int       k_alu, k_mfpu, cyc;
        k_alu = 0; k_mfpu = 0; exp_src = 1'b0;
        reset_dut();
        wr_ack = 1'b1; alu_req = 1'b1; mfpu_req = 1'b1;
        drive_alu(mk_beat(1'b0, 0)); drive_mfpu(mk_beat(1'b1, 0));
        for (cyc = 0; cyc < 40; cyc++) begin
            if (cyc == 20) begin alu_req = 1'b0; mfpu_req = 1'b0; end
            mid();
            if (cyc > 0 && cyc < 20) begin
                n_checks++; if (wr_valid !== 1'b1 || wr_src !== exp_src) begin n_fail++; $display("FAIL rr_order cyc %0d: got valid %b src %b want 1 %b", cyc, wr_valid, wr_src, exp_src); end
                exp_src = ~exp_src;
            end
            if (wr_valid) begin
                have = wr_src ? (q_mfpu.size() != 0) : (q_alu.size() != 0);
                n_checks++;
                if (!have) begin
                    n_fail++; $display("FAIL rr_extra_beat cyc %0d: got src %b id %0d want none", cyc, wr_src, wr_id);
                end else begin
                    if (wr_src) exp = q_mfpu.pop_front(); else exp = q_alu.pop_front();
                    if (dut_beat() !== exp) begin n_fail++; $display("FAIL rr_payload cyc %0d: got %h want %h", cyc, dut_beat(), exp); end
                    n_checks++;
                    if ((wr_src ? mfpu_done : alu_done) !== (8'd1 << exp.id) || (wr_src ? alu_done : mfpu_done) !== 8'h00) begin
                        n_fail++; $display("FAIL rr_done cyc %0d: got alu %b mfpu %b want id %0d on src %b", cyc, alu_done, mfpu_done, exp.id, wr_src);
                    end
                end
            end
            if (alu_gnt) begin q_alu.push_back(mk_beat(1'b0, k_alu)); k_alu++; end
            if (mfpu_gnt) begin q_mfpu.push_back(mk_beat(1'b1, k_mfpu)); k_mfpu++; end
            if (cyc > 20 && !wr_valid && q_alu.size() == 0 && q_mfpu.size() == 0) break;
            next();
            drive_alu(mk_beat(1'b0, k_alu)); drive_mfpu(mk_beat(1'b1, k_mfpu));
        end
        n_checks++; if (q_alu.size() != 0 || q_mfpu.size() != 0) begin n_fail++; $display("FAIL rr_drain: got %0d/%0d pending want 0/0", q_alu.size(), q_mfpu.size()); end
        n_checks++; if (k_alu < 9 || k_mfpu < 9) begin n_fail++; $display("FAIL rr_rate: got %0d/%0d grants want >=9 each", k_alu, k_mfpu); end
        next();
        wr_ack = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_gnt_v, ack_v;
        tb_beat_t   exp;
        int         k;
        exp_gnt_v = 8'b0100_0011;
        ack_v     = 8'b0010_0000;
        k = 0;
        reset_dut();
        alu_req = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            wr_ack = ack_v[cyc];
            drive_alu(mk_beat(1'b0, 40 + k));
            mid();
            n_checks++; if (alu_gnt !== exp_gnt_v[cyc]) begin n_fail++; $display("FAIL bp_gnt cyc %0d: got %b want %b", cyc, alu_gnt, exp_gnt_v[cyc]); end
            exp = mk_beat(1'b0, (cyc <= 5) ? 40 : 41);
            n_checks++;
            if (cyc == 0) begin
                if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid cyc 0: got %b want 0", wr_valid); end
            end else if (wr_valid !== 1'b1 || dut_beat() !== exp) begin
                n_fail++; $display("FAIL bp_hold cyc %0d: got %b %h want 1 %h", cyc, wr_valid, dut_beat(), exp);
            end
            n_checks++; if (alu_done !== ((cyc == 5) ? 8'h01 : 8'h00)) begin n_fail++; $display("FAIL bp_done cyc %0d: got %b", cyc, alu_done); end
            if (alu_gnt) k++;
            next();
        end
        alu_req = 1'b0; wr_ack = 1'b1;
        mid();
        n_checks++; if (dut_beat() !== mk_beat(1'b0, 41) || alu_done !== 8'h02) begin n_fail++; $display("FAIL bp_drain1: got %h/%b want %h/00000010", dut_beat(), alu_done, mk_beat(1'b0, 41)); end
        next();
        mid();
        n_checks++; if (dut_beat() !== mk_beat(1'b0, 42) || alu_done !== 8'h04) begin n_fail++; $display("FAIL bp_drain2: got %h/%b want %h/00000100", dut_beat(), alu_done, mk_beat(1'b0, 42)); end
        next();
        mid();
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", wr_valid); end
        next();
        wr_ack = 1'b0;
    endtask

    task automatic test_lock();
        tb_beat_t m, a;
        m = mk_beat(1'b1, 7);
        a = mk_beat(1'b0, 4);
        reset_dut();
        drive_mfpu(m); mfpu_req = 1'b1;
        next();
        mfpu_req = 1'b0; drive_alu(a); alu_req = 1'b1;
        mid();
        n_checks++; if (wr_valid !== 1'b1 || wr_src !== 1'b1 || alu_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_first: got valid %b src %b gnt %b want 1 1 1", wr_valid, wr_src, alu_gnt); end
        next();
        alu_req = 1'b0;
        mid();
        n_checks++; if (wr_src !== 1'b1 || dut_beat() !== m) begin n_fail++; $display("FAIL lock_hold: got src %b %h want 1 %h", wr_src, dut_beat(), m); end
        next();
        wr_ack = 1'b1;
        mid();
        n_checks++; if (wr_src !== 1'b1 || mfpu_done !== (8'd1 << m.id) || alu_done !== 8'h00) begin n_fail++; $display("FAIL lock_ack: got src %b done %b/%b", wr_src, alu_done, mfpu_done); end
        next();
        mid();
        n_checks++; if (wr_valid !== 1'b1 || wr_src !== 1'b0 || dut_beat() !== a || alu_done !== (8'd1 << a.id)) begin n_fail++; $display("FAIL lock_follow: got %b %b %h want 1 0 %h", wr_valid, wr_src, dut_beat(), a); end
        next();
        wr_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        tb_beat_t na, nm;
        na = mk_beat(1'b0, 20);
        nm = mk_beat(1'b1, 21);
        reset_dut();
        alu_req = 1'b1; mfpu_req = 1'b1;
        drive_alu(mk_beat(1'b0, 10)); drive_mfpu(mk_beat(1'b1, 10));
        next();
        drive_alu(mk_beat(1'b0, 11)); drive_mfpu(mk_beat(1'b1, 11));
        next();
        mid();
        n_checks++; if ({alu_gnt, mfpu_gnt} !== 2'b00 || wr_valid !== 1'b1) begin n_fail++; $display("FAIL rm_full: got gnt %b valid %b want 00 1", {alu_gnt, mfpu_gnt}, wr_valid); end
        next();
        rst_n = 1'b0; wr_ack = 1'b1;
        drive_alu(na); drive_mfpu(nm);
        mid();
        n_checks++; if ({wr_valid, alu_gnt, mfpu_gnt} !== 3'b000) begin n_fail++; $display("FAIL rm_during: got %b want 000", {wr_valid, alu_gnt, mfpu_gnt}); end
        next();
        rst_n = 1'b1;
        mid();
        n_checks++; if ({wr_valid, alu_gnt, mfpu_gnt} !== 3'b000 || {alu_done, mfpu_done} !== 16'h0) begin n_fail++; $display("FAIL rm_after: got %b done %h want 000 0000", {wr_valid, alu_gnt, mfpu_gnt}, {alu_done, mfpu_done}); end
        next();
        mid();
        n_checks++; if ({alu_gnt, mfpu_gnt} !== 2'b11 || wr_valid !== 1'b0) begin n_fail++; $display("FAIL rm_regrant: got gnt %b valid %b want 11 0", {alu_gnt, mfpu_gnt}, wr_valid); end
        next();
        alu_req = 1'b0; mfpu_req = 1'b0;
        mid();
        n_checks++; if (wr_src !== 1'b0 || dut_beat() !== na || alu_done !== (8'd1 << na.id)) begin n_fail++; $display("FAIL rm_alu_first: got src %b %h want 0 %h", wr_src, dut_beat(), na); end
        next();
        mid();
        n_checks++; if (wr_src !== 1'b1 || dut_beat() !== nm || mfpu_done !== (8'd1 << nm.id)) begin n_fail++; $display("FAIL rm_mfpu_next: got src %b %h want 1 %h", wr_src, dut_beat(), nm); end
        next();
        mid();
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_stale: got valid %b id %0d want 0", wr_valid, wr_id); end
        next();
        wr_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_alu();
        test_alternate();
        test_backpressure();
        test_lock();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
